// File: rtl/wb_stim_responder_pkg.sv
// Shared types for the stimulus responder: bus widths, responder FSM state
// encoding and the record of a captured store.
package guvm_wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} wb_rsp_state_e;

  typedef struct packed {
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
    logic [WB_DW/8-1:0] sel;
  } wb_store_t;

endpackage

// File: rtl/wb_stim_responder_if.sv
// Bundle of the stimulus push port, the core-facing Wishbone slave port and
// the store result port. Names are from the responder's point of view.
//   slave  : the responder (drives o_*)
//   master : core + driver + monitor (drive i_*)
interface wb_stim_responder_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int CW = 5
);
  logic          i_stim_valid;
  logic [DW-1:0] i_stim_data;
  logic          o_stim_ready;
  logic [CW-1:0] o_fifo_count;

  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [AW-1:0]   i_wb_adr;
  logic [DW/8-1:0] i_wb_sel;
  logic [DW-1:0]   i_wb_dat;
  logic [DW-1:0]   o_wb_dat;
  logic            o_wb_ack;
  logic            o_wb_err;

  logic            o_res_valid;
  logic [DW-1:0]   o_res_data;
  logic [AW-1:0]   o_res_adr;
  logic [DW/8-1:0] o_res_sel;
  logic            i_res_ack;

  modport slave (
    input  i_stim_valid, i_stim_data, i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr,
           i_wb_sel, i_wb_dat, i_res_ack,
    output o_stim_ready, o_fifo_count, o_wb_dat, o_wb_ack, o_wb_err,
           o_res_valid, o_res_data, o_res_adr, o_res_sel
  );

  modport master (
    output i_stim_valid, i_stim_data, i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr,
           i_wb_sel, i_wb_dat, i_res_ack,
    input  o_stim_ready, o_fifo_count, o_wb_dat, o_wb_ack, o_wb_err,
           o_res_valid, o_res_data, o_res_adr, o_res_sel
  );
endinterface

// File: rtl/wb_stim_responder_fifo.sv
// wb_stim_fifo: synchronous FIFO with exact occupancy count and same-cycle
// push+pop (also when full). rdata is the current head, combinational.
//   push/wdata : enqueue (ignored when full unless popping this cycle)
//   pop        : dequeue head (ignored when empty)
//   full/empty/count : status
module wb_stim_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being freed by the pop is the one the push reuses.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  // Pointers wrap naturally: DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_stim_responder.sv
// wb_stim_responder: Wishbone slave behind the core master port. Reads pop
// the stimulus FIFO, writes land in a single result slot. A cycle that
// cannot be served waits up to TIMEOUT_CYC cycles and then gets o_wb_err.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : stimulus push, Wishbone slave, store result port
module wb_stim_responder
  import guvm_wb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int DW          = WB_DW,
  parameter int AW          = WB_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  wb_stim_responder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_ACK  = ACK;
  localparam logic [1:0] ST_ERR  = ERR;

  logic [1:0]    state, state_nx;
  logic          we_q;
  logic [TW-1:0] tmo_cnt;
  wb_store_t     res_q;
  logic          res_vld;

  logic          full, empty, stim_ready, push_now, pop_now, req, can_serve;
  logic [DW-1:0] head;

  assign pop_now    = (state == ST_ACK) && !we_q;
  assign stim_ready = !full || pop_now;
  assign push_now   = bus.i_stim_valid && stim_ready;
  assign req        = bus.i_wb_cyc && bus.i_wb_stb;

  // A push in flight counts as data so the ack follows the push by one cycle,
  // matching the write side where i_res_ack frees the slot immediately.
  assign can_serve  = bus.i_wb_we ? (!res_vld || bus.i_res_ack)
                                  : (!empty || push_now);

  wb_stim_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push_now),
    .pop   (pop_now),
    .wdata (bus.i_stim_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (bus.o_fifo_count)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = can_serve ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (!bus.i_wb_cyc)                          state_nx = ST_IDLE;
        else if (can_serve)                         state_nx = ST_ACK;
        else if (tmo_cnt == TW'(TIMEOUT_CYC - 1))   state_nx = ST_ERR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && req) we_q <= bus.i_wb_we;
      // Counter only runs while staying in WAIT; loads 0 on entry.
      if (state == ST_WAIT && state_nx == ST_WAIT) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Capture takes priority over a same-cycle consumer release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_vld <= 1'b0;
      res_q   <= '0;
    end else if (state == ST_ACK && we_q) begin
      res_vld <= 1'b1;
      res_q   <= '{adr: bus.i_wb_adr, dat: bus.i_wb_dat, sel: bus.i_wb_sel};
    end else if (bus.i_res_ack) begin
      res_vld <= 1'b0;
    end
  end

  assign bus.o_stim_ready = stim_ready;
  assign bus.o_wb_ack     = (state == ST_ACK);
  assign bus.o_wb_err     = (state == ST_ERR);
  assign bus.o_wb_dat     = pop_now ? head : '0;
  assign bus.o_res_valid  = res_vld;
  assign bus.o_res_data   = res_q.dat;
  assign bus.o_res_adr    = res_q.adr;
  assign bus.o_res_sel    = res_q.sel;
endmodule

// File: tb/tb_wb_stim_responder.sv
// Directed bench for wb_stim_responder. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
module tb_wb_stim_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  wb_stim_responder_if #(.DW(32), .AW(32), .CW(5)) bus ();

  wb_stim_responder #(.DEPTH(16), .TIMEOUT_CYC(64), .DW(32), .AW(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    bus.i_stim_valid = 1'b1;
    bus.i_stim_data  = d;
    tick();
    bus.i_stim_valid = 1'b0;
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    bus.i_wb_we  = we;
    bus.i_wb_adr = adr;
    bus.i_wb_dat = dat;
    bus.i_wb_sel = sel;
  endtask

  task automatic drop();
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  // Single read expected to ack on the next edge with data d.
  task automatic read_ok(input string tag, input logic [31:0] d);
    req(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk({tag, "_ack"}, 64'(bus.o_wb_ack), 64'd1);
    chk({tag, "_dat"}, 64'(bus.o_wb_dat), 64'(d));
    drop();
    tick();
  endtask

  initial begin
    bus.i_stim_valid = 0; bus.i_stim_data = 0; bus.i_res_ack = 0;
    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
    bus.i_wb_adr = 0; bus.i_wb_sel = 0; bus.i_wb_dat = 0;
    tick(); tick();
    chk("rst_ack",   64'(bus.o_wb_ack), 64'd0);
    chk("rst_err",   64'(bus.o_wb_err), 64'd0);
    chk("rst_ready", 64'(bus.o_stim_ready), 64'd1);
    chk("rst_count", 64'(bus.o_fifo_count), 64'd0);
    chk("rst_resv",  64'(bus.o_res_valid), 64'd0);
    chk("rst_dat",   64'(bus.o_wb_dat), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic read with data present.
    push(32'hF0800003);
    chk("rd1_cnt_before", 64'(bus.o_fifo_count), 64'd1);
    req(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("rd1_ack", 64'(bus.o_wb_ack), 64'd1);
    chk("rd1_dat", 64'(bus.o_wb_dat), 64'hF0800003);
    drop();
    tick();
    chk("rd1_cnt_after", 64'(bus.o_fifo_count), 64'd0);
    chk("rd1_ack_low",   64'(bus.o_wb_ack), 64'd0);
    chk("rd1_dat_low",   64'(bus.o_wb_dat), 64'd0);

    // Read stalls on empty FIFO; push 5 cycles later; ack the cycle after.
    req(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("rd2_wait_ack", 64'(bus.o_wb_ack), 64'd0);
    push(32'h00000005);
    chk("rd2_ack", 64'(bus.o_wb_ack), 64'd1);
    chk("rd2_dat", 64'(bus.o_wb_dat), 64'h5);
    chk("rd2_err", 64'(bus.o_wb_err), 64'd0);
    drop();
    tick();
    chk("rd2_cnt", 64'(bus.o_fifo_count), 64'd0);

    // Timeout: 64 WAIT cycles, then a single err pulse.
    req(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    n = 0;
    while (!bus.o_wb_err && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd64);
    chk("tmo_ack",    64'(bus.o_wb_ack), 64'd0);
    chk("tmo_dat",    64'(bus.o_wb_dat), 64'd0);
    chk("tmo_cnt",    64'(bus.o_fifo_count), 64'd0);
    drop();
    tick();
    chk("tmo_err_once", 64'(bus.o_wb_err), 64'd0);
    push(32'hA5A50001);
    read_ok("tmo_next", 32'hA5A50001);

    // Store capture, then a second store stalls until the slot is released.
    req(1'b1, 32'h00000100, 32'h00000007, 4'hF);
    tick();
    chk("wr1_ack", 64'(bus.o_wb_ack), 64'd1);
    drop();
    tick();
    chk("wr1_resv", 64'(bus.o_res_valid), 64'd1);
    chk("wr1_dat",  64'(bus.o_res_data), 64'h7);
    chk("wr1_adr",  64'(bus.o_res_adr), 64'h100);
    chk("wr1_sel",  64'(bus.o_res_sel), 64'hF);
    req(1'b1, 32'h00000104, 32'h00000009, 4'h3);
    tick(); tick(); tick();
    chk("wr2_stall", 64'(bus.o_wb_ack), 64'd0);
    bus.i_res_ack = 1'b1;
    tick();
    bus.i_res_ack = 1'b0;
    chk("wr2_ack",  64'(bus.o_wb_ack), 64'd1);
    chk("wr2_freed", 64'(bus.o_res_valid), 64'd0);
    drop();
    tick();
    chk("wr2_resv", 64'(bus.o_res_valid), 64'd1);
    chk("wr2_dat",  64'(bus.o_res_data), 64'h9);
    chk("wr2_adr",  64'(bus.o_res_adr), 64'h104);
    chk("wr2_sel",  64'(bus.o_res_sel), 64'h3);
    bus.i_res_ack = 1'b1;
    tick();
    bus.i_res_ack = 1'b0;
    chk("wr2_drained", 64'(bus.o_res_valid), 64'd0);

    // Fill to 16, drop a push when full, push during pop, drain in order.
    for (int i = 0; i < 16; i++) push(32'h1000 + i);
    chk("full_ready", 64'(bus.o_stim_ready), 64'd0);
    chk("full_count", 64'(bus.o_fifo_count), 64'd16);
    push(32'hDEAD);
    chk("full_drop", 64'(bus.o_fifo_count), 64'd16);
    req(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("fp_ack",   64'(bus.o_wb_ack), 64'd1);
    chk("fp_dat",   64'(bus.o_wb_dat), 64'h1000);
    chk("fp_ready", 64'(bus.o_stim_ready), 64'd1);
    drop();
    push(32'h2000);
    chk("fp_count", 64'(bus.o_fifo_count), 64'd16);
    for (int i = 0; i < 16; i++)
      read_ok("drain", (i < 15) ? 32'h1001 + i : 32'h2000);
    chk("drain_count", 64'(bus.o_fifo_count), 64'd0);

    // Reset while waiting: nothing acked, everything cleared.
    push(32'h77);
    req(1'b1, 32'h200, 32'h11, 4'h1);
    tick();
    drop();
    tick();
    chk("rw_resv", 64'(bus.o_res_valid), 64'd1);
    req(1'b1, 32'h204, 32'h12, 4'h1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rw_ack",   64'(bus.o_wb_ack), 64'd0);
    chk("rw_err",   64'(bus.o_wb_err), 64'd0);
    chk("rw_count", 64'(bus.o_fifo_count), 64'd0);
    chk("rw_resv0", 64'(bus.o_res_valid), 64'd0);
    drop();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_ack_after", 64'(bus.o_wb_ack), 64'd0);
    push(32'h3333);
    chk("rw_cnt1", 64'(bus.o_fifo_count), 64'd1);
    read_ok("rw_first", 32'h3333);
    chk("rw_cnt0", 64'(bus.o_fifo_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
